// File: rtl/os_feed_pkg.sv
// Shared types and instruction encodings for the output-stationary array feed controller.
package os_feed_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        FLUSH,
        SHIFT,
        GAP,
        DONE
    } state_t;

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_EXEC = 2'b01;

endpackage

// File: rtl/os_feed_pipe.sv
// Strobe pipeline: instruction one cycle after an issue, FIFO reads one cycle after that,
// plus the per-column psum shift chain driven by shift steps.
module os_feed_pipe
    import os_feed_pkg::*;
#(
    parameter int unsigned COL = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           issue,
    input  logic           step,
    output logic [1:0]     inst,
    output logic           rd_en,
    output logic [COL-1:0] shift_psum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst       <= INST_NOP;
            rd_en      <= 1'b0;
            shift_psum <= '0;
        end else begin
            inst       <= issue ? INST_EXEC : INST_NOP;
            rd_en      <= (inst == INST_EXEC);
            shift_psum <= {shift_psum[COL-2:0], step};
        end
    end

endmodule

// File: rtl/os_array_feed_ctrl.sv
// Output-stationary FIFO-to-array sequencer: per tile, feeds operands, drains, shifts psums
// out under output-FIFO backpressure, and repeats for the configured number of tiles.
module os_array_feed_ctrl
    import os_feed_pkg::*;
#(
    parameter int unsigned COL     = 8,
    parameter int unsigned ROW     = 8,
    parameter int unsigned KIJ_MAX = 9,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TILE_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CNT_W-1:0]  cfg_feed_len_i,
    input  logic [CNT_W-1:0]  cfg_drain_i,
    input  logic [TILE_W-1:0] cfg_num_tiles_i,
    input  logic              l0_rd_ready_i,
    input  logic              ififo_rd_ready_i,
    input  logic              ofifo_wr_ready_i,
    output logic [1:0]        inst_o,
    output logic              l0_rd_en_o,
    output logic              ififo_rd_en_o,
    output logic [COL-1:0]    shift_psum_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned MAX_FEED = ROW * KIJ_MAX;
    localparam int unsigned SH_W     = $clog2(COL + 1);
    localparam logic [SH_W-1:0] SH_LAST = SH_W'(COL - 1);

    if (MAX_FEED >= (1 << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too narrow for ROW*KIJ_MAX");
    end

    logic [1:0] rst_sync;
    logic       rst_n;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cfg_len_q, cfg_drain_q;
    logic [TILE_W-1:0] cfg_tiles_q;
    logic [CNT_W-1:0]  feed_cnt_q, drain_cnt_q;
    logic [SH_W-1:0]   shift_cnt_q;
    logic [TILE_W-1:0] tile_cnt_q;
    logic              done_q;

    logic [CNT_W-1:0]  feed_inc, drain_inc;
    logic [SH_W-1:0]   shift_inc;
    logic [TILE_W-1:0] tile_inc;
    logic              issue, step, tile_end;
    logic              rd_en;

    // Assertion is asynchronous through the sync flops; release lands on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign feed_inc  = feed_cnt_q + CNT_W'(1);
    assign drain_inc = drain_cnt_q + CNT_W'(1);
    assign shift_inc = shift_cnt_q + SH_W'(1);
    assign tile_inc  = tile_cnt_q + TILE_W'(1);

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        step     = 1'b0;
        tile_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = (cfg_num_tiles_i == '0) ? DONE : FEED;
            end
            FEED: begin
                if (cfg_len_q == '0) begin
                    state_d = (cfg_drain_q == '0) ? SHIFT : FLUSH;
                end else if (l0_rd_ready_i && ififo_rd_ready_i) begin
                    issue = 1'b1;
                    if (feed_inc == cfg_len_q) state_d = (cfg_drain_q == '0) ? SHIFT : FLUSH;
                end
            end
            FLUSH: begin
                if (drain_inc == cfg_drain_q) state_d = SHIFT;
            end
            SHIFT: begin
                if (ofifo_wr_ready_i) begin
                    step = 1'b1;
                    if (shift_cnt_q == SH_LAST) begin
                        tile_end = 1'b1;
                        if (tile_inc == cfg_tiles_q) state_d = DONE;
                        else                         state_d = (cfg_drain_q == '0) ? FEED : GAP;
                    end
                end
            end
            GAP: begin
                if (drain_inc == cfg_drain_q) state_d = FEED;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d  = IDLE;
            issue    = 1'b0;
            step     = 1'b0;
            tile_end = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_len_q   <= '0;
            cfg_drain_q <= '0;
            cfg_tiles_q <= '0;
            feed_cnt_q  <= '0;
            drain_cnt_q <= '0;
            shift_cnt_q <= '0;
            tile_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i && !abort_i) begin
                cfg_len_q   <= cfg_feed_len_i;
                cfg_drain_q <= cfg_drain_i;
                cfg_tiles_q <= cfg_num_tiles_i;
            end
            // Counters clear whenever their phase is left, which also covers abort.
            feed_cnt_q  <= (state_d == FEED) ? (issue ? feed_inc : feed_cnt_q) : '0;
            drain_cnt_q <= ((state_q == FLUSH || state_q == GAP) && state_d == state_q)
                           ? drain_inc : '0;
            shift_cnt_q <= (state_d == SHIFT) ? (step ? shift_inc : shift_cnt_q) : '0;
            tile_cnt_q  <= (state_d == IDLE) ? '0 : (tile_end ? tile_inc : tile_cnt_q);
            done_q      <= (state_q == DONE) && !abort_i;
        end
    end

    os_feed_pipe #(.COL(COL)) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .step       (step),
        .inst       (inst_o),
        .rd_en      (rd_en),
        .shift_psum (shift_psum_o)
    );

    assign l0_rd_en_o    = rd_en;
    assign ififo_rd_en_o = rd_en;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

endmodule

// File: tb/tb_os_array_feed_ctrl.sv
// Self-checking bench for os_array_feed_ctrl against a timeline/count reference model.
module tb_os_array_feed_ctrl;

    localparam int COL = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_i, abort_i;
    logic [7:0] cfg_feed_len_i, cfg_drain_i;
    logic [3:0] cfg_num_tiles_i;
    logic       l0r, ifr, ofr;
    logic [1:0] inst_o;
    logic       l0_rd_en_o, ififo_rd_en_o, busy_o, done_o;
    logic [COL-1:0] shift_psum_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int n_inst, n_rd, n_sh0, n_shtop, n_done, n_busy, viol;
    int first_inst, first_rd, done_cyc;
    int sh0_q[$];
    logic prev_l0, prev_if, prev_inst;
    logic [COL-1:0] prev_sh;

    os_array_feed_ctrl #(
        .COL(COL), .ROW(8), .KIJ_MAX(9), .CNT_W(8), .TILE_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .abort_i(abort_i),
        .cfg_feed_len_i(cfg_feed_len_i), .cfg_drain_i(cfg_drain_i),
        .cfg_num_tiles_i(cfg_num_tiles_i), .l0_rd_ready_i(l0r),
        .ififo_rd_ready_i(ifr), .ofifo_wr_ready_i(ofr), .inst_o(inst_o),
        .l0_rd_en_o(l0_rd_en_o), .ififo_rd_en_o(ififo_rd_en_o),
        .shift_psum_o(shift_psum_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation and protocol rules, sampled mid-cycle.
    always @(negedge clk) begin
        if (inst_o == 2'b01) begin
            n_inst++;
            if (first_inst < 0) first_inst = cyc;
            if (!(prev_l0 && prev_if)) viol++;
        end
        if (inst_o != 2'b01 && inst_o != 2'b00) viol++;
        if (l0_rd_en_o) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
            if (!prev_inst) viol++;
        end
        if (l0_rd_en_o !== ififo_rd_en_o) viol++;
        if (shift_psum_o[0]) begin
            n_sh0++;
            sh0_q.push_back(cyc);
        end
        if (shift_psum_o[COL-1]) n_shtop++;
        for (int k = 1; k < COL; k++)
            if (shift_psum_o[k] && !prev_sh[k-1]) viol++;
        if (done_o) begin
            n_done++;
            done_cyc = cyc;
            if (busy_o) viol++;
        end
        if (busy_o) n_busy++;
        prev_l0   = l0r;
        prev_if   = ifr;
        prev_inst = (inst_o == 2'b01);
        prev_sh   = shift_psum_o;
    end

    // Reference timeline with all readiness high: done_o cycle relative to the start cycle.
    function automatic int exp_done_rel(input int L, input int D, input int T);
        int feed;
        feed = (L == 0) ? 1 : L;
        if (T == 0) return 2;
        return 1 + T * (feed + D + COL) + (T - 1) * D + 1;
    endfunction

    task automatic clear_counts();
        n_inst = 0; n_rd = 0; n_sh0 = 0; n_shtop = 0; n_done = 0; n_busy = 0; viol = 0;
        first_inst = -1; first_rd = -1; done_cyc = -1;
        sh0_q.delete();
    endtask

    task automatic launch(input int L, input int D, input int T, output int s);
        @(posedge clk); #1;
        cfg_feed_len_i  = 8'(L);
        cfg_drain_i     = 8'(D);
        cfg_num_tiles_i = 4'(T);
        start_i = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // mode 0: all ready; 1: random readiness; 2: l0 toggles each cycle
    task automatic run_job(input int L, input int D, input int T, input int mode, output int s);
        int ok;
        clear_counts();
        l0r = 1'b1; ifr = 1'b1; ofr = 1'b1;
        launch(L, D, T, s);
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            if (n_done > 0) begin
                ok = 1;
                break;
            end
            if (mode == 1) begin
                l0r = ($urandom_range(0, 9) < 7);
                ifr = ($urandom_range(0, 9) < 7);
                ofr = ($urandom_range(0, 9) < 6);
            end else if (mode == 2) begin
                l0r = ~l0r;
            end
            @(posedge clk); #1;
        end
        l0r = 1'b1; ifr = 1'b1; ofr = 1'b1;
        checks++;
        if (ok !== 1) begin
            failures++;
            $display("FAIL job_timeout: done_o seen=%0d required=1 (L=%0d D=%0d T=%0d)", ok, L, D, T);
        end
        repeat (COL + 4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({inst_o, l0_rd_en_o, ififo_rd_en_o, shift_psum_o, busy_o, done_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: inst=%b rd=%b/%b shift=%b busy=%b done=%b required all 0",
                     inst_o, l0_rd_en_o, ififo_rd_en_o, shift_psum_o, busy_o, done_o);
        end
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({inst_o, l0_rd_en_o, shift_psum_o, busy_o, done_o} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b inst=%b required 0", busy_o, inst_o);
        end
    endtask

    task automatic test_default();
        int s;
        run_job(72, 8, 2, 0, s);
        checks++;
        if (first_inst - s !== 2) begin
            failures++; $display("FAIL first_inst: got %0d required 2", first_inst - s);
        end
        checks++;
        if (first_rd - s !== 3) begin
            failures++; $display("FAIL first_rd: got %0d required 3", first_rd - s);
        end
        checks++;
        if (n_inst !== 144 || n_rd !== 144) begin
            failures++; $display("FAIL default_counts: inst=%0d rd=%0d required 144", n_inst, n_rd);
        end
        checks++;
        if (n_sh0 !== 16 || n_shtop !== 16) begin
            failures++; $display("FAIL default_shift: bit0=%0d top=%0d required 16", n_sh0, n_shtop);
        end
        checks++;
        if (done_cyc - s !== 186 || n_done !== 1) begin
            failures++; $display("FAIL default_done: at %0d x%0d required 186 x1", done_cyc - s, n_done);
        end
        checks++;
        if (n_busy !== 185) begin
            failures++; $display("FAIL default_busy: got %0d required 185", n_busy);
        end
        checks++;
        if (viol !== 0) begin
            failures++; $display("FAIL default_rules: violations=%0d required 0", viol);
        end
    endtask

    task automatic test_l0_toggle();
        int s;
        run_job(72, 8, 1, 2, s);
        checks++;
        if (n_rd !== 72) begin
            failures++; $display("FAIL toggle_rd: got %0d required 72", n_rd);
        end
        checks++;
        if (viol !== 0) begin
            failures++; $display("FAIL toggle_rules: violations=%0d required 0", viol);
        end
        checks++;
        if (n_busy !== done_cyc - s - 1) begin
            failures++; $display("FAIL toggle_busy: got %0d required %0d", n_busy, done_cyc - s - 1);
        end
    endtask

    task automatic test_backpressure();
        int s, hole, pre;
        clear_counts();
        l0r = 1'b1; ifr = 1'b1; ofr = 1'b1;
        launch(72, 8, 1, s);
        for (int i = 0; i < 300 && n_done == 0; i++) begin
            if (cyc == s + 84) ofr = 1'b0;
            if (cyc == s + 89) ofr = 1'b1;
            @(posedge clk); #1;
        end
        ofr = 1'b1;
        repeat (COL + 4) @(posedge clk);
        #1;
        hole = 0; pre = 0;
        foreach (sh0_q[i]) begin
            if (sh0_q[i] - s >= 85 && sh0_q[i] - s <= 89) hole++;
            if (sh0_q[i] - s >= 82 && sh0_q[i] - s <= 84) pre++;
        end
        checks++;
        if (n_sh0 !== 8) begin
            failures++; $display("FAIL bp_bit0_count: got %0d required 8", n_sh0);
        end
        checks++;
        if (hole !== 0 || pre !== 3) begin
            failures++; $display("FAIL bp_hole: in-hole=%0d before=%0d required 0 and 3", hole, pre);
        end
        checks++;
        if (done_cyc - s !== 95) begin
            failures++; $display("FAIL bp_done: at %0d required 95", done_cyc - s);
        end
    endtask

    task automatic test_zero_tiles();
        int s;
        run_job(72, 8, 0, 0, s);
        checks++;
        if (done_cyc - s !== 2) begin
            failures++; $display("FAIL zero_tiles_done: at %0d required 2", done_cyc - s);
        end
        checks++;
        if (n_inst !== 0 || n_rd !== 0) begin
            failures++; $display("FAIL zero_tiles_reads: inst=%0d rd=%0d required 0", n_inst, n_rd);
        end
    endtask

    task automatic test_abort();
        int s;
        clear_counts();
        l0r = 1'b1; ifr = 1'b1; ofr = 1'b1;
        launch(72, 8, 2, s);
        while (cyc < s + 21) begin
            @(posedge clk); #1;
        end
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++; $display("FAIL abort_idle: busy=%b required 0", busy_o);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (n_rd < 20 || n_rd > 22) begin
            failures++; $display("FAIL abort_trailing_rd: got %0d required 20..22", n_rd);
        end
        checks++;
        if (n_done !== 0) begin
            failures++; $display("FAIL abort_no_done: got %0d required 0", n_done);
        end
        abort_i = 1'b1; start_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0; start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++; $display("FAIL abort_beats_start: busy=%b required 0", busy_o);
        end
        repeat (3) @(posedge clk);
        run_job(72, 8, 1, 0, s);
        checks++;
        if (n_rd !== 72 || done_cyc - s !== 90) begin
            failures++; $display("FAIL abort_refeed: rd=%0d done=%0d required 72 and 90", n_rd, done_cyc - s);
        end
    endtask

    task automatic test_reset_mid_shift();
        int s;
        clear_counts();
        launch(72, 8, 1, s);
        while (cyc < s + 84) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({inst_o, l0_rd_en_o, ififo_rd_en_o, shift_psum_o, busy_o, done_o} !== '0) begin
            failures++;
            $display("FAIL async_reset: shift=%b busy=%b inst=%b required all 0", shift_psum_o, busy_o, inst_o);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        run_job(72, 8, 1, 0, s);
        checks++;
        if (n_rd !== 72 || n_sh0 !== 8 || done_cyc - s !== 90) begin
            failures++;
            $display("FAIL post_reset_tile: rd=%0d bit0=%0d done=%0d required 72 8 90", n_rd, n_sh0, done_cyc - s);
        end
    endtask

    task automatic test_random_cfg();
        int s, L, D, T;
        for (int it = 0; it < 6; it++) begin
            L = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 72));
            D = $urandom_range(0, 10);
            T = $urandom_range(0, 3);
            run_job(L, D, T, 0, s);
            checks++;
            if (n_inst !== T * L || n_rd !== T * L) begin
                failures++; $display("FAIL rnd_feed_count: inst=%0d rd=%0d required %0d", n_inst, n_rd, T * L);
            end
            checks++;
            if (n_sh0 !== T * COL || n_shtop !== T * COL) begin
                failures++; $display("FAIL rnd_shift_count: bit0=%0d top=%0d required %0d", n_sh0, n_shtop, T * COL);
            end
            checks++;
            if (done_cyc - s !== exp_done_rel(L, D, T)) begin
                failures++;
                $display("FAIL rnd_done_time: got %0d required %0d (L=%0d D=%0d T=%0d)",
                         done_cyc - s, exp_done_rel(L, D, T), L, D, T);
            end
        end
    endtask

    task automatic test_random_ready();
        int s, L, D, T;
        for (int it = 0; it < 5; it++) begin
            L = $urandom_range(1, 72);
            D = $urandom_range(0, 6);
            T = $urandom_range(1, 3);
            run_job(L, D, T, 1, s);
            checks++;
            if (n_inst !== T * L || n_rd !== T * L || n_sh0 !== T * COL) begin
                failures++;
                $display("FAIL rr_counts: inst=%0d rd=%0d bit0=%0d required %0d %0d %0d",
                         n_inst, n_rd, n_sh0, T * L, T * L, T * COL);
            end
            checks++;
            if (viol !== 0 || n_done !== 1) begin
                failures++; $display("FAIL rr_rules: violations=%0d done=%0d required 0 and 1", viol, n_done);
            end
            checks++;
            if (n_busy !== done_cyc - s - 1) begin
                failures++; $display("FAIL rr_busy: got %0d required %0d", n_busy, done_cyc - s - 1);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start_i = 1'b0; abort_i = 1'b0;
        cfg_feed_len_i = '0; cfg_drain_i = '0; cfg_num_tiles_i = '0;
        l0r = 1'b1; ifr = 1'b1; ofr = 1'b1;
        prev_l0 = 1'b0; prev_if = 1'b0; prev_inst = 1'b0; prev_sh = '0;
        clear_counts();
        test_reset();
        test_default();
        test_l0_toggle();
        test_backpressure();
        test_zero_tiles();
        test_abort();
        test_reset_mid_shift();
        test_random_cfg();
        test_random_ready();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
